// File: rtl/ysyx_24080014_axil_sram_slave.sv
// AXI4-lite subordinate over a word-organised RAM: independent write and read FSMs,
// byte-strobed writes, OKAY/SLVERR decode, programmable read latency.
module ysyx_24080014_axil_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(RD_LAT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [31:0] mem [DEPTH_WORDS];

    // 33-bit subtraction so addresses below ADDR_BASE show up as a borrow
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return !off[32] && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return IDX_W'(off >> 2);
    endfunction

    // ---------------- write channel ----------------
    logic [0:0]  w_state;
    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_fire, w_fire, w_commit, wr_ok;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    always_comb begin
        aw_fire  = awvalid && awready;
        w_fire   = wvalid && wready;
        wr_addr  = aw_held ? aw_addr_q : awaddr;
        wr_data  = w_held  ? wdata_q   : wdata;
        wr_strb  = w_held  ? wstrb_q   : wstrb;
        w_commit = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_ok    = in_range(wr_addr);
    end

    always_ff @(posedge clk) begin
        if (w_commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_commit) begin
                        w_state <= W_RESP;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end else begin
                        // only one half has arrived; park it until the other shows up
                        if (aw_fire) begin
                            aw_held   <= 1'b1;
                            awready   <= 1'b0;
                            aw_addr_q <= awaddr;
                        end
                        if (w_fire) begin
                            w_held  <= 1'b1;
                            wready  <= 1'b0;
                            wdata_q <= wdata;
                            wstrb_q <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        bresp   <= RESP_OKAY;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] ar_addr_q;
    logic        rd_ok;

    always_comb rd_ok = in_range(ar_addr_q);

    // RAM sampled with the pre-edge contents, so a same-edge write is not visible
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            r_cnt     <= '0;
            ar_addr_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_addr_q <= araddr;
                        r_cnt     <= CNT_INIT;
                        arready   <= 1'b0;
                        r_state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        rvalid  <= 1'b1;
                        rdata   <= rd_ok ? mem[word_idx(ar_addr_q)] : 32'h0;
                        rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_axil_sram_slave.sv
// Directed bench for the AXI4-lite SRAM subordinate (small RAM, read latency 3).
module tb_ysyx_24080014_axil_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;

    logic        clk = 1'b0, rst = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int total = 0;
    int bad   = 0;

    ysyx_24080014_axil_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW and W together; lat counts edges from the handshake edge to bvalid seen
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output int lat);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin step(); lat++; end
        resp = bresp;
        bready = 1'b1; step(); bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                      output int lat);
        arvalid = 1'b1; araddr = a;
        step();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin step(); lat++; end
        d = rdata; resp = rresp;
        rready = 1'b1; step(); rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b want=1", awready); end
        total++; if (wready !== 1'b1) begin bad++; $display("FAIL rst_wready got=%b want=1", wready); end
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b want=1", arready); end
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b want=0", bvalid); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", rvalid); end
        total++; if (bresp !== 2'b00) begin bad++; $display("FAIL rst_bresp got=%b want=00", bresp); end
        total++; if (rresp !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b want=00", rresp); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    endtask

    task automatic test_aligned_write();
        logic [1:0] resp; logic [31:0] d; int lat;
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL t1_blat got=%0d want=1", lat); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL t1_bresp got=%b want=00", resp); end
        total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL t1_ready_after_b got=%b want=11", {awready, wready}); end
        rd(32'h8000_0010, d, resp, lat);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_rdata got=%h want=deadbeef", d); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL t1_rresp got=%b want=00", resp); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL t1_rlat got=%0d want=%0d", lat, LAT); end
    endtask

    task automatic test_w_first();
        logic [1:0] resp; logic [31:0] d; int lat;
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
        step();
        wvalid = 1'b0;
        total++; if ({wready, awready, bvalid} !== 3'b010) begin bad++; $display("FAIL t2_after_w got=%b want=010", {wready, awready, bvalid}); end
        step(); step();
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL t2_early_b got=%b want=0", bvalid); end
        awvalid = 1'b1; awaddr = 32'h8000_0020;
        step();
        awvalid = 1'b0;
        total++; if ({bvalid, bresp, awready} !== 4'b1000) begin bad++; $display("FAIL t2_b got=%b want=1000", {bvalid, bresp, awready}); end
        bready = 1'b1; step(); bready = 1'b0;
        rd(32'h8000_0020, d, resp, lat);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL t2_rdata got=%h want=12345678", d); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; int lat;
        wr(32'h8000_0030, 32'h1122_3344, 4'hF, resp, lat);
        wr(32'h8000_0030, 32'hAABB_CCDD, 4'b0101, resp, lat);
        rd(32'h8000_0030, d, resp, lat);
        total++; if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL t3_strb got=%h want=11bb33dd", d); end
        wr(32'h8000_0030, 32'hFFFF_FFFF, 4'b0000, resp, lat);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL t3_zero_strb_resp got=%b want=00", resp); end
        rd(32'h8000_0033, d, resp, lat);
        total++; if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL t3_zero_strb_data got=%h want=11bb33dd", d); end
    endtask

    task automatic test_rd_latency();
        int lat; logic [31:0] held;
        arvalid = 1'b1; araddr = 32'h8000_0010;
        step();
        arvalid = 1'b0;
        total++; if (arready !== 1'b0) begin bad++; $display("FAIL t4_arready_busy got=%b want=0", arready); end
        lat = 0;
        while (!rvalid && lat < 20) begin step(); lat++; end
        total++; if (lat !== 3) begin bad++; $display("FAIL t4_lat got=%0d want=3", lat); end
        held = rdata;
        total++; if (held !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t4_rdata got=%h want=deadbeef", held); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if ({rvalid, rdata} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL t4_stall%0d got=%b/%h want=1/deadbeef", i, rvalid, rdata); end
        end
        rready = 1'b1; step(); rready = 1'b0;
        total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL t4_after_r got=%b want=01", {rvalid, arready}); end
    endtask

    task automatic test_range();
        logic [1:0] resp; logic [31:0] d; int lat;
        wr(BASE, 32'hA5A5_0000, 4'hF, resp, lat);
        wr(32'h8000_03FC, 32'h5A5A_03FC, 4'hF, resp, lat);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL t5_last_bresp got=%b want=00", resp); end
        wr(32'h7FFF_FFFC, 32'hBAD0_0001, 4'hF, resp, lat);
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL t5_low_bresp got=%b want=10", resp); end
        wr(32'h8000_0400, 32'hBAD0_0002, 4'hF, resp, lat);
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL t5_high_bresp got=%b want=10", resp); end
        rd(32'h7FFF_FFFC, d, resp, lat);
        total++; if ({resp, d} !== {2'b10, 32'h0}) begin bad++; $display("FAIL t5_low_r got=%b/%h want=10/0", resp, d); end
        rd(32'h8000_0400, d, resp, lat);
        total++; if ({resp, d} !== {2'b10, 32'h0}) begin bad++; $display("FAIL t5_high_r got=%b/%h want=10/0", resp, d); end
        rd(BASE, d, resp, lat);
        total++; if (d !== 32'hA5A5_0000) begin bad++; $display("FAIL t5_word0 got=%h want=a5a50000", d); end
        rd(32'h8000_03FC, d, resp, lat);
        total++; if ({resp, d} !== {2'b00, 32'h5A5A_03FC}) begin bad++; $display("FAIL t5_last got=%b/%h want=00/5a5a03fc", resp, d); end
    endtask

    task automatic test_same_edge();
        logic [1:0] resp; logic [31:0] d; int lat;
        wr(32'h8000_0060, 32'h0101_0101, 4'hF, resp, lat);
        arvalid = 1'b1; araddr = 32'h8000_0060;
        step();
        arvalid = 1'b0;
        step(); step();
        awvalid = 1'b1; awaddr = 32'h8000_0060; wvalid = 1'b1; wdata = 32'h0202_0202; wstrb = 4'hF;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        total++; if ({bvalid, rvalid, rdata} !== {2'b11, 32'h0101_0101}) begin bad++; $display("FAIL t7_same_edge got=%b%b/%h want=11/01010101", bvalid, rvalid, rdata); end
        bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
        rd(32'h8000_0060, d, resp, lat);
        total++; if (d !== 32'h0202_0202) begin bad++; $display("FAIL t7_new got=%h want=02020202", d); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] d; int lat;
        awvalid = 1'b1; awaddr = 32'h8000_0050; wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h8000_0010;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++; if ({bvalid, rvalid, arready} !== 3'b100) begin bad++; $display("FAIL t6_pre got=%b want=100", {bvalid, rvalid, arready}); end
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin bad++; $display("FAIL t6_post got=%b want=00111", {bvalid, rvalid, awready, wready, arready}); end
        step(); step(); step(); step();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL t6_dropped_r got=%b want=0", rvalid); end
        rd(32'h8000_0010, d, resp, lat);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t6_keep got=%h want=deadbeef", d); end
        rd(32'h8000_0050, d, resp, lat);
        total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL t6_committed got=%h want=cafef00d", d); end
    endtask

    initial begin
        test_reset();
        test_aligned_write();
        test_w_first();
        test_strobe();
        test_rd_latency();
        test_range();
        test_same_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
